// File: rtl/hist2d_mem_ctrl.sv
// 2D I/Q histogram RAM controller: clear, read-modify-write accumulate, stream out (opt. HIST_CLEAR_ON_READ_EN).
// Latency: first CLEAR write 1 cycle after start; 2 cycles per accepted pair; out_valid 2 cycles after READ_ISSUE.
// Backpressure: bin_ready drops for the write-back cycle; readout beats hold until out_ready.
module hist2d_mem_ctrl #(
  parameter int BIN_BITS = 6,
  parameter int COUNT_W  = 16
) (
  input  logic                  clk100,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [15:0]           num_shots,
  input  logic                  bin_valid,
  output logic                  bin_ready,
  input  logic [BIN_BITS-1:0]   i_bin_coord,
  input  logic [BIN_BITS-1:0]   q_bin_coord,
  output logic [2*BIN_BITS-1:0] mem_addr,
  output logic                  mem_we,
  output logic [COUNT_W-1:0]    mem_wdata,
  input  logic [COUNT_W-1:0]    mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BIN_BITS-1:0]   out_i,
  output logic [BIN_BITS-1:0]   out_q,
  output logic [COUNT_W-1:0]    out_count,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  saturated
);
  localparam int AW = 2 * BIN_BITS;
  localparam logic [AW-1:0]      ADDR_LAST = '1;
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

  localparam logic [2:0] S_IDLE         = 3'd0;
  localparam logic [2:0] S_CLEAR        = 3'd1;
  localparam logic [2:0] S_ACCUM        = 3'd2;
  localparam logic [2:0] S_DRAIN        = 3'd3;
  localparam logic [2:0] S_READ_ISSUE   = 3'd4;
  localparam logic [2:0] S_READ_PRESENT = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [15:0]        shots_q, shots_d;
  logic [15:0]        accepted_q, accepted_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               s2_vld_q, s2_vld_d;
  logic [AW-1:0]      s2_addr_q, s2_addr_d;
  logic               sat_q, sat_d;
  logic               out_valid_q, out_valid_d;
  logic [COUNT_W-1:0] out_count_q, out_count_d;
  logic               done_q, done_d;
`ifdef HIST_CLEAR_ON_READ_EN
  logic               clean_q, clean_d;
`endif
  logic [COUNT_W-1:0] incr;

  assign incr = (mem_rdata == CNT_MAX) ? CNT_MAX : mem_rdata + 1'b1;

  always_comb begin
    state_d     = state_q;
    shots_d     = shots_q;
    accepted_d  = accepted_q;
    addr_d      = addr_q;
    s2_vld_d    = 1'b0;
    s2_addr_d   = s2_addr_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    done_d      = 1'b0;
`ifdef HIST_CLEAR_ON_READ_EN
    clean_d     = clean_q;
`endif
    bin_ready   = 1'b0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;

    // S2 write-back owns the port the cycle after every accept
    if (s2_vld_q) begin
      mem_addr  = s2_addr_q;
      mem_we    = 1'b1;
      mem_wdata = incr;
      if (incr == CNT_MAX) sat_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shots_d    = num_shots;
          accepted_d = '0;
          sat_d      = 1'b0;
          addr_d     = '0;
          state_d    = S_CLEAR;
`ifdef HIST_CLEAR_ON_READ_EN
          if (clean_q) state_d = (num_shots == '0) ? S_DRAIN : S_ACCUM;
`endif
        end
      end
      S_CLEAR: begin
        mem_addr = addr_q;
        mem_we   = 1'b1;
        addr_d   = addr_q + 1'b1;
        if (addr_q == ADDR_LAST) begin
          state_d = (shots_q == '0) ? S_DRAIN : S_ACCUM;
`ifdef HIST_CLEAR_ON_READ_EN
          clean_d = 1'b1;
`endif
        end
      end
      S_ACCUM: begin
        if (accepted_q == shots_q) begin
          state_d = S_DRAIN;
        end else if (!s2_vld_q) begin
          bin_ready = 1'b1;
          if (bin_valid) begin
            mem_addr   = {i_bin_coord, q_bin_coord};
            s2_vld_d   = 1'b1;
            s2_addr_d  = {i_bin_coord, q_bin_coord};
            accepted_d = accepted_q + 16'd1;
`ifdef HIST_CLEAR_ON_READ_EN
            clean_d    = 1'b0;
`endif
          end
        end
      end
      S_DRAIN: begin
        if (!s2_vld_q) begin
          addr_d  = '0;
          state_d = S_READ_ISSUE;
        end
      end
      S_READ_ISSUE: begin
        mem_addr = addr_q;
        state_d  = S_READ_PRESENT;
      end
      S_READ_PRESENT: begin
        mem_addr = addr_q;
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_count_d = mem_rdata;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef HIST_CLEAR_ON_READ_EN
          mem_we      = 1'b1;
`endif
          if (addr_q == ADDR_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
`ifdef HIST_CLEAR_ON_READ_EN
            clean_d = 1'b1;
`endif
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_READ_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      shots_q     <= '0;
      accepted_q  <= '0;
      addr_q      <= '0;
      s2_vld_q    <= 1'b0;
      s2_addr_q   <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      done_q      <= 1'b0;
`ifdef HIST_CLEAR_ON_READ_EN
      clean_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shots_q     <= shots_d;
      accepted_q  <= accepted_d;
      addr_q      <= addr_d;
      s2_vld_q    <= s2_vld_d;
      s2_addr_q   <= s2_addr_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      done_q      <= done_d;
`ifdef HIST_CLEAR_ON_READ_EN
      clean_q     <= clean_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign saturated = sat_q;
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_i     = addr_q[AW-1:BIN_BITS];
  assign out_q     = addr_q[BIN_BITS-1:0];
  assign out_last  = out_valid_q && (addr_q == ADDR_LAST);

endmodule

// File: tb/tb_hist2d_mem_ctrl.sv
// Directed bench for hist2d_mem_ctrl with a behavioural synchronous-read count RAM.
module tb_hist2d_mem_ctrl;
  localparam int BB = 6;
  localparam int CW = 16;
  localparam int AW = 12;
  localparam int NB = 4096;

  logic          clk100 = 1'b0;
  logic          reset_n;
  logic          start;
  logic [15:0]   num_shots;
  logic          bin_valid;
  logic          bin_ready;
  logic [BB-1:0] i_bin_coord, q_bin_coord;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [CW-1:0] mem_wdata;
  logic [CW-1:0] mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [BB-1:0] out_i, out_q;
  logic [CW-1:0] out_count;
  logic          out_last;
  logic          busy, done, saturated;

  always #5 clk100 = ~clk100;

  hist2d_mem_ctrl #(.BIN_BITS(BB), .COUNT_W(CW)) dut (
    .clk100(clk100), .reset_n(reset_n), .start(start), .num_shots(num_shots),
    .bin_valid(bin_valid), .bin_ready(bin_ready),
    .i_bin_coord(i_bin_coord), .q_bin_coord(q_bin_coord),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
    .out_count(out_count), .out_last(out_last),
    .busy(busy), .done(done), .saturated(saturated)
  );

  // Single-port RAM model with a bench-side preload port used only while the DUT is not writing
  logic [CW-1:0] ram [NB];
  logic          preload_en = 1'b0;
  logic [AW-1:0] preload_addr = '0;
  logic [CW-1:0] preload_dat = '0;
  always @(posedge clk100) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    else if (preload_en) ram[preload_addr] <= preload_dat;
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;
  int beat_cnt, done_cnt, ready_cnt, we_cnt, busy_at_done, first_bad;
  logic [CW-1:0] got_count [NB];
  logic [AW-1:0] got_addr  [NB];
  logic          got_last  [NB];
  logic [CW-1:0] exp_count [NB];

  always @(negedge clk100) begin
    if (out_valid && out_ready) begin
      if (beat_cnt < NB) begin
        got_count[beat_cnt] = out_count;
        got_addr[beat_cnt]  = {out_i, out_q};
        got_last[beat_cnt]  = out_last;
      end
      beat_cnt++;
    end
    if (done) begin
      done_cnt++;
      if (busy) busy_at_done++;
    end
    if (bin_ready) ready_cnt++;
    if (mem_we) we_cnt++;
  end

  function automatic int readout_bad();
    int n = 0;
    first_bad = -1;
    for (int k = 0; k < NB; k++) begin
      if (got_count[k] !== exp_count[k] || got_addr[k] !== AW'(k) || got_last[k] !== (k == NB - 1)) begin
        if (first_bad < 0) first_bad = k;
        n++;
      end
    end
    return n;
  endfunction

  task automatic clear_stats();
    beat_cnt = 0; done_cnt = 0; ready_cnt = 0; we_cnt = 0; busy_at_done = 0;
    for (int k = 0; k < NB; k++) begin
      exp_count[k] = '0;
      got_count[k] = 'x;
      got_addr[k]  = 'x;
      got_last[k]  = 1'bx;
    end
  endtask

  // Called and returns at posedge+#1
  task automatic pulse_start(input logic [15:0] n);
    num_shots = n;
    start = 1'b1;
    @(posedge clk100); #1;
    start = 1'b0;
  endtask

  task automatic send_pair(input logic [BB-1:0] i, input logic [BB-1:0] q);
    int t = 0;
    bin_valid = 1'b1; i_bin_coord = i; q_bin_coord = q;
    @(negedge clk100);
    while (!bin_ready && t < 10000) begin @(negedge clk100); t++; end
    checks++;
    if (bin_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: bin_ready=%b required 1", bin_ready);
      bin_valid = 1'b0;
      @(posedge clk100); #1;
      return;
    end
    @(posedge clk100); #1;
    bin_valid = 1'b0;
    @(negedge clk100);
    checks++;
    if (bin_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_accept: bin_ready=%b required 0", bin_ready);
    end
    @(posedge clk100); #1;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cnt == 0 && t < 20000) begin @(negedge clk100); t++; end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL done_timeout: done_cnt=%0d required 1", done_cnt);
    end
    repeat (5) @(negedge clk100);
    @(posedge clk100); #1;
  endtask

  task automatic test_reset();
    int t = 0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk100);
    #1;
    checks++;
    if ({bin_ready, mem_we, mem_addr, mem_wdata, out_valid, out_i, out_q, out_count,
         out_last, busy, done, saturated} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b addr=%h busy=%b valid=%b required all 0",
               mem_we, mem_addr, busy, out_valid);
    end
    reset_n = 1'b1;
    @(posedge clk100); #1;
    clear_stats();
    pulse_start(16'd5);
    @(negedge clk100);
    while (!(mem_we && mem_addr == AW'(100)) && t < 5000) begin @(negedge clk100); t++; end
    checks++;
    if (!(mem_we === 1'b1 && mem_addr === AW'(100))) begin
      errors++;
      $display("FAIL clear_reach_100: addr=%h we=%b required addr 064 we 1", mem_addr, mem_we);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({bin_ready, mem_we, mem_addr, mem_wdata, out_valid, out_i, out_q, out_count,
         out_last, busy, done, saturated} !== '0) begin
      errors++;
      $display("FAIL reset_mid_clear: got we=%b addr=%h busy=%b required all 0",
               mem_we, mem_addr, busy);
    end
    @(posedge clk100); #1;
    reset_n = 1'b1;
    @(posedge clk100); #1;
  endtask

  task automatic test_zero_shots();
    clear_stats();
    pulse_start(16'd0);
    @(negedge clk100);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== '0 || mem_wdata !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_clear_write: we=%b addr=%h wdata=%h busy=%b required 1 000 0000 1",
               mem_we, mem_addr, mem_wdata, busy);
    end
    @(posedge clk100); #1;
    wait_done();
    checks++;
`ifdef HIST_CLEAR_ON_READ_EN
    if (we_cnt != 2 * NB) begin
`else
    if (we_cnt != NB) begin
`endif
      errors++;
      $display("FAIL zero_write_count: got %0d writes", we_cnt);
    end
    checks++;
    if (ready_cnt != 0) begin
      errors++;
      $display("FAIL zero_no_ready: bin_ready cycles=%0d required 0", ready_cnt);
    end
    checks++;
    if (beat_cnt != NB || done_cnt != 1 || busy_at_done != 0) begin
      errors++;
      $display("FAIL zero_beats_done: beats=%0d done=%0d busy_at_done=%0d required 4096 1 0",
               beat_cnt, done_cnt, busy_at_done);
    end
    checks++;
    if (readout_bad() != 0) begin
      errors++;
      $display("FAIL zero_readout: first bad beat %0d count=%h addr=%h last=%b required 0000",
               first_bad, got_count[first_bad], got_addr[first_bad], got_last[first_bad]);
    end
  endtask

  task automatic test_accumulate_stall();
    int t = 0;
    int unstable = 0;
    logic [2*BB+CW:0] snap;
    clear_stats();
    exp_count[0]    = 16'd2;
    exp_count[NB-1] = 16'd1;
    pulse_start(16'd3);
    send_pair(6'd0, 6'd0);
    send_pair(6'd0, 6'd0);
    send_pair(6'd63, 6'd63);
    repeat (3) @(negedge clk100);
    checks++;
    if (bin_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_last_shot: bin_ready=%b required 0", bin_ready);
    end
    while (beat_cnt < 17 && t < 20000) begin @(negedge clk100); t++; end
    @(posedge clk100); #1;
    out_ready = 1'b0;
    t = 0;
    @(negedge clk100);
    while (!out_valid && t < 100) begin @(negedge clk100); t++; end
    snap = {out_i, out_q, out_count, out_last};
    checks++;
    if (out_valid !== 1'b1 || {out_i, out_q} !== AW'(17) || out_count !== '0) begin
      errors++;
      $display("FAIL stall_beat_id: valid=%b addr=%h count=%h required 1 011 0000",
               out_valid, {out_i, out_q}, out_count);
    end
    repeat (10) begin
      @(negedge clk100);
      if ({out_i, out_q, out_count, out_last} !== snap || out_valid !== 1'b1) unstable++;
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL stall_hold: %0d unstable cycles required 0", unstable);
    end
    @(posedge clk100); #1;
    out_ready = 1'b1;
    wait_done();
    checks++;
    if (beat_cnt != NB || done_cnt != 1) begin
      errors++;
      $display("FAIL accum_beats_done: beats=%0d done=%0d required 4096 1", beat_cnt, done_cnt);
    end
    checks++;
    if (readout_bad() != 0) begin
      errors++;
      $display("FAIL accum_readout: first bad beat %0d count=%h addr=%h last=%b required %h",
               first_bad, got_count[first_bad], got_addr[first_bad], got_last[first_bad],
               exp_count[first_bad]);
    end
    checks++;
    if (saturated !== 1'b0) begin
      errors++;
      $display("FAIL accum_not_saturated: saturated=%b required 0", saturated);
    end
  endtask

  task automatic test_saturation();
    int t = 0;
    clear_stats();
    exp_count[{6'd5, 6'd7}] = 16'hFFFF;
    pulse_start(16'd3);
    @(negedge clk100);
    while (!bin_ready && t < 10000) begin @(negedge clk100); t++; end
    @(posedge clk100); #1;
    preload_addr = {6'd5, 6'd7};
    preload_dat  = 16'hFFFE;
    preload_en   = 1'b1;
    @(posedge clk100); #1;
    preload_en   = 1'b0;
    repeat (3) send_pair(6'd5, 6'd7);
    wait_done();
    checks++;
    if (got_count[{6'd5, 6'd7}] !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_count: got %h required ffff", got_count[{6'd5, 6'd7}]);
    end
    checks++;
    if (saturated !== 1'b1) begin
      errors++;
      $display("FAIL sat_flag: saturated=%b required 1", saturated);
    end
    checks++;
    if (readout_bad() != 0) begin
      errors++;
      $display("FAIL sat_readout: first bad beat %0d count=%h required %h",
               first_bad, got_count[first_bad], exp_count[first_bad]);
    end
  endtask

`ifdef HIST_CLEAR_ON_READ_EN
  task automatic test_back_to_back();
    int nz = 0;
    for (int r = 0; r < 2; r++) begin
      clear_stats();
      exp_count[{6'd1, 6'd1}] = (r == 0) ? 16'd2 : 16'd1;
      pulse_start((r == 0) ? 16'd2 : 16'd1);
      @(negedge clk100);
      checks++;
      if (mem_we !== 1'b0 || bin_ready !== 1'b1 || saturated !== 1'b0) begin
        errors++;
        $display("FAIL skip_clear run%0d: we=%b ready=%b sat=%b required 0 1 0",
                 r, mem_we, bin_ready, saturated);
      end
      @(posedge clk100); #1;
      repeat ((r == 0) ? 2 : 1) send_pair(6'd1, 6'd1);
      wait_done();
      checks++;
      if (readout_bad() != 0) begin
        errors++;
        $display("FAIL b2b_readout run%0d: first bad beat %0d count=%h required %h",
                 r, first_bad, got_count[first_bad], exp_count[first_bad]);
      end
    end
    for (int k = 0; k < NB; k++) if (ram[k] !== '0) nz++;
    checks++;
    if (nz != 0) begin
      errors++;
      $display("FAIL ram_left_zero: %0d nonzero bins required 0", nz);
    end
  endtask
`endif

  initial begin
    start = 1'b0; num_shots = '0; bin_valid = 1'b0;
    i_bin_coord = '0; q_bin_coord = '0; out_ready = 1'b1;
    clear_stats();
    test_reset();
    test_zero_shots();
    test_accumulate_stall();
    test_saturation();
`ifdef HIST_CLEAR_ON_READ_EN
    test_back_to_back();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hist2d_mem_ctrl.md
# hist2d_mem_ctrl

Controller for the 2D I/Q histogram count memory. It clears the memory, then accumulates a programmed number of shots from the per-axis bin searchers by read-modify-write increments. When the run completes it streams every bin count out over a ready/valid port. It sits between the paired i/q binary-search binners and the analysis output mux, and owns the single-port count RAM.

## Interface
- BIN_BITS, 6, bits per axis coordinate; RAM depth = 2^(2·BIN_BITS)
- COUNT_W, 16, bits per bin count
- clk100  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; starts a run when IDLE, ignored otherwise
- num_shots  in  16  shots to accumulate; sampled on start
- bin_valid  in  1  coordinate pair present
- bin_ready  out  1  controller accepts pair this cycle
- i_bin_coord, q_bin_coord  in  BIN_BITS  bin coordinates; all-ones = out-of-range bin, counted normally
- mem_addr  out  2·BIN_BITS  RAM address = {i, q}
- mem_we  out  1  RAM write enable
- mem_wdata  out  COUNT_W  RAM write data
- mem_rdata  in  COUNT_W  RAM read data, valid 1 cycle after mem_addr (synchronous read)
- out_valid  out  1  readout beat valid
- out_ready  in  1  downstream accepts beat
- out_i, out_q  out  BIN_BITS  coordinates of beat
- out_count  out  COUNT_W  bin count
- out_last  out  1  final beat (address all-ones)
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after last beat accepted
- saturated  out  1  sticky; a bin hit max count this run

## Operation
- States: IDLE, CLEAR, ACCUM, DRAIN, READ_ISSUE, READ_PRESENT.
- IDLE: on start, latch num_shots, clear shot counter and saturated. Next state is CLEAR, or ACCUM when clearing is skipped (see Configuration).
- CLEAR: write 0 to addresses 0..2^(2·BIN_BITS)−1, one per cycle, mem_we=1. After the last address go to ACCUM.
- ACCUM: bin_ready=1 while accepted < num_shots. A pair is accepted on bin_valid && bin_ready.
  - Two-stage pipeline. S1 drives mem_addr (read). S2, next cycle, writes sat(rdata+1) to the same address.
  - Read and write on the same cycle are not possible on the single port. Each accept therefore occupies the port for 2 cycles, and bin_ready is deasserted on the cycle after an accept.
  - Increment saturates at 2^COUNT_W−1 and sets saturated; the count never wraps.
- When accepted == num_shots, go to DRAIN. num_shots=0 goes straight from CLEAR (or IDLE) to DRAIN.
- DRAIN: wait for the final S2 write to complete, reset the address counter to 0, then go to READ_ISSUE.
- READ_ISSUE: drive mem_addr = counter. Next state READ_PRESENT.
- READ_PRESENT: register rdata into out_count, set out_valid, and hold all out_* stable until out_ready.
  - On handshake, clear out_valid. If the address was the last one, pulse done and go to IDLE. Otherwise increment the address and return to READ_ISSUE.
- start is ignored outside IDLE. bin_valid is ignored outside ACCUM.
- Reset mid-operation: the FSM returns to IDLE and RAM contents are undefined.

## Timing
- Reset values: bin_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, out_valid=0, out_i=0, out_q=0, out_count=0, out_last=0, busy=0, done=0, saturated=0.
- start→first CLEAR write: 1 cycle. CLEAR lasts 4096 cycles at BIN_BITS=6.
- Accumulation throughput: 1 pair per 2 cycles.
- Readout: minimum 2 cycles per beat. out_valid rises 2 cycles after entering READ_ISSUE.
- done asserts the cycle after the last handshake. busy falls in the same cycle.

## Configuration
- HIST_CLEAR_ON_READ_EN defined:
  - READ_PRESENT writes 0 to the held address on the handshake cycle, so the memory is left zeroed.
  - A clean flag, cleared by reset and set after each full readout or CLEAR pass, lets start skip CLEAR when set.
  - A run aborted by reset clears the flag, so the next run clears again.
- Undefined: every run performs CLEAR and readout never writes.

## Test plan
- Reset during CLEAR at address 100 → all outputs at reset values. Next start performs a full 4096-cycle CLEAR.
- num_shots=3; pairs (0,0),(0,0),(63,63) → readout bin 0 count=2, bin 4095 count=1 with out_last=1, all others 0, one done pulse.
- Preload bin (5,7)=0xFFFE, num_shots=3 all to (5,7) → out_count=0xFFFF, saturated=1.
- num_shots=0 → no bin_ready assertion, 4096 beats all zero, done pulse.
- out_ready held low for 10 cycles on beat 17 → out_i/out_q/out_count stable, no skipped or repeated beat.
- HIST_CLEAR_ON_READ_EN: two back-to-back runs → second run's CLEAR is skipped, and its counts exclude the first run's shots.
